// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadow BCD, glyph decode, leading-zero/blank/blink gating.
// seg/an registered, 1-cycle latency from state and live controls; no backpressure, load is captured unconditionally.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_digit;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic                    dark;

  // Walk from the most significant digit down; a digit is a leading zero while everything above it is zero too.
  always_comb begin : lz_blk
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow[4*i +: 4] == 4'd0);
      lz_mask[i] = lz_suppress & upper_zero;
    end
  end

  assign cur_digit = shadow[4*idx +: 4];
  assign an_lit    = ~(NUM_DIGITS'(1) << idx);

  always_comb begin
    glyph = 7'h3F;
    case (cur_digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

  // First cycle of every slot stays dark so the previous digit's segments never ghost onto the next anode.
  assign dark = (scan_cnt == '0) | blank_mask[idx] | (blink_en[idx] & blink_phase) | lz_mask[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      scan_cnt    <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg         <= 7'h7F;
      an          <= '1;
    end else begin
      if (load)
        shadow <= digits_in;

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      seg <= dark ? 7'h7F : glyph;
      an  <= dark ? '1 : an_lit;
    end
  end

endmodule
